// File: rtl/dibu_alu_pkg.sv
// Shared opcode encodings, flag bit positions and widths for the DIBU ALU.
package dibu_alu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned FLAGS_W = 8;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SHL   = 3'b101,
    ALU_SHR   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_P = 4;

  // Status word as seen by the control unit; upper bits are reserved zeros.
  typedef struct packed {
    logic [2:0] rsvd;
    logic       p;
    logic       v;
    logic       c;
    logic       n;
    logic       z;
  } alu_flags_t;

endpackage

// File: rtl/dibu_alu_flags.sv
// Condition-flag generator: Z/N/P from the result, C/V selected by opcode.
module dibu_alu_flags
  import dibu_alu_pkg::*;
(
  input  alu_op_e             op,
  input  logic [DATA_W-1:0]   res,
  input  logic                a_msb,
  input  logic                a_lsb,
  input  logic                b_msb,
  input  logic                add_carry,
  input  logic                sub_borrow,
  output logic [FLAGS_W-1:0]  flags_c
);

  alu_flags_t f;

  always_comb begin
    f      = '0;
    f.z    = (res == '0);
    f.n    = res[DATA_W-1];
    f.p    = ^res;
    unique case (op)
      ALU_ADD: begin
        f.c = add_carry;
        f.v = (a_msb == b_msb) && (res[DATA_W-1] != a_msb);
      end
      ALU_SUB: begin
        f.c = sub_borrow;
        f.v = (a_msb != b_msb) && (res[DATA_W-1] != a_msb);
      end
      ALU_SHL: f.c = a_msb;
      ALU_SHR: f.c = a_lsb;
      default: begin
        f.c = 1'b0;
        f.v = 1'b0;
      end
    endcase
  end

  assign flags_c = FLAGS_W'(f);

endmodule

// File: rtl/dibu_alu.sv
// DIBU 8-bit ALU: combinational result and flags plus an enabled flag register.
module dibu_alu
  import dibu_alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [OP_W-1:0]     op,
  input  logic                flags_en,
  output logic [DATA_W-1:0]   out,
  output logic [FLAGS_W-1:0]  flags,
  output logic [FLAGS_W-1:0]  flags_q
);

  alu_op_e         op_e;
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign op_e = alu_op_e'(op);
  assign sum  = (DATA_W+1)'(a) + (DATA_W+1)'(b);
  // Ninth bit of the widened difference is the unsigned borrow (a < b).
  assign diff = (DATA_W+1)'(a) - (DATA_W+1)'(b);

  always_comb begin
    out = '0;
    unique case (op_e)
      ALU_ADD:   out = sum[DATA_W-1:0];
      ALU_SUB:   out = diff[DATA_W-1:0];
      ALU_AND:   out = a & b;
      ALU_OR:    out = a | b;
      ALU_XOR:   out = a ^ b;
      ALU_SHL:   out = {a[DATA_W-2:0], 1'b0};
      ALU_SHR:   out = {1'b0, a[DATA_W-1:1]};
      ALU_PASSB: out = b;
      default:   out = '0;
    endcase
  end

  dibu_alu_flags u_flags (
    .op         (op_e),
    .res        (out),
    .a_msb      (a[DATA_W-1]),
    .a_lsb      (a[0]),
    .b_msb      (b[DATA_W-1]),
    .add_carry  (sum[DATA_W]),
    .sub_borrow (diff[DATA_W]),
    .flags_c    (flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (flags_en) begin
      flags_q <= flags;
    end
  end

endmodule

// File: tb/tb_dibu_alu.sv
// Directed self-checking bench for dibu_alu: result, flags and flag register.
module tb_dibu_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       flags_en;
  logic [7:0] out;
  logic [7:0] flags;
  logic [7:0] flags_q;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  exp_q  = 8'h00;

  dibu_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .op       (op),
    .flags_en (flags_en),
    .out      (out),
    .flags    (flags),
    .flags_q  (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // Drive one vector after a posedge, check combinational outputs and the register at negedge.
  task automatic vec(input string tag, input logic [2:0] o, input logic [7:0] va,
                     input logic [7:0] vb, input logic en,
                     input logic [7:0] exp_out, input logic [7:0] exp_flags);
    @(posedge clk);
    #1;
    op = o; a = va; b = vb; flags_en = en;
    @(negedge clk);
    check8({tag, ".out"}, out, exp_out);
    check8({tag, ".flags"}, flags, exp_flags);
    check8({tag, ".flags_q"}, flags_q, exp_q);
    if (en) exp_q = exp_flags;
  endtask

  initial begin
    rst_n = 1'b0; flags_en = 1'b1; op = 3'b000; a = 8'hFF; b = 8'h01;
    #1;
    check8("rst_immediate", flags_q, 8'h00);
    check8("rst_comb_out", out, 8'h00);
    check8("rst_comb_flags", flags, 8'h05);
    @(negedge clk);
    check8("rst_held_over_edge", flags_q, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check8("load_after_release", flags_q, 8'h05);
    exp_q = 8'h05;

    vec("hold_en0",   3'b001, 8'h03, 8'h05, 1'b0, 8'hFE, 8'h16);
    vec("hold_en0_2", 3'b010, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check8("hold_still", flags_q, 8'h05);

    vec("add_ovf",    3'b000, 8'h7F, 8'h01, 1'b1, 8'h80, 8'h1A);
    vec("add_carry",  3'b000, 8'hFF, 8'h01, 1'b1, 8'h00, 8'h05);
    vec("sub_borrow", 3'b001, 8'h03, 8'h05, 1'b1, 8'hFE, 8'h16);
    vec("sub_ovf",    3'b001, 8'h80, 8'h01, 1'b1, 8'h7F, 8'h18);
    vec("sub_zero",   3'b001, 8'h5A, 8'h5A, 1'b1, 8'h00, 8'h01);
    vec("and",        3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00);
    vec("or",         3'b011, 8'h80, 8'h01, 1'b1, 8'h81, 8'h02);
    vec("xor_zero",   3'b100, 8'hAA, 8'hAA, 1'b1, 8'h00, 8'h01);
    vec("xor",        3'b100, 8'h0F, 8'h01, 1'b1, 8'h0E, 8'h10);
    vec("shl",        3'b101, 8'h81, 8'h00, 1'b1, 8'h02, 8'h14);
    vec("shl_nocarry",3'b101, 8'h40, 8'hFF, 1'b1, 8'h80, 8'h12);
    vec("shr",        3'b110, 8'h01, 8'hFF, 1'b1, 8'h00, 8'h05);
    vec("shr_msb0",   3'b110, 8'hFE, 8'h00, 1'b1, 8'h7F, 8'h10);
    vec("passb_zero", 3'b111, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h01);
    vec("passb",      3'b111, 8'h00, 8'hC1, 1'b1, 8'hC1, 8'h12);
    vec("add_plain",  3'b000, 8'h10, 8'h22, 1'b0, 8'h32, 8'h10);

    // Asynchronous reset mid-cycle, away from any clock edge.
    @(negedge clk);
    check8("pre_async_rst", flags_q, exp_q);
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_rst", flags_q, 8'h00);
    check8("async_rst_out", out, 8'h32);
    #4;
    rst_n = 1'b1;
    exp_q = 8'h00;
    vec("post_rst", 3'b000, 8'h7F, 8'h01, 1'b1, 8'h80, 8'h1A);
    @(posedge clk);
    @(negedge clk);
    check8("post_rst_load", flags_q, 8'h1A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
